// File: rtl/bomb_fuse_if.sv
// bomb_fuse_if: player-side button/position inputs and bomb status outputs of one bomb stage.
interface bomb_fuse_if;
    logic       place;
    logic       stunned;
    logic [5:0] playerPosX;
    logic [5:0] playerPosY;
    logic [5:0] bombPosX;
    logic [5:0] bombPosY;
    logic       bombActive;
    logic       bombExploded;
    logic [3:0] fuseRemaining;
    logic       ready;
    modport master (
        output place, stunned, playerPosX, playerPosY,
        input  bombPosX, bombPosY, bombActive, bombExploded, fuseRemaining, ready
    );
    modport slave (
        input  place, stunned, playerPosX, playerPosY,
        output bombPosX, bombPosY, bombActive, bombExploded, fuseRemaining, ready
    );
endinterface

// File: rtl/bomb_fuse_controller.sv
// bomb_fuse_controller: places a bomb on a button edge, runs the fuse, pulses the explosion, then locks out for a cooldown.
module bomb_fuse_controller #(
    parameter int N                = 50000000,
    parameter int FUSE_SECONDS     = 3,
    parameter int COOLDOWN_SECONDS = 2
) (
    input logic        clk,
    input logic        reset,
    bomb_fuse_if.slave bus
);
    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(N - 1);
    localparam logic [3:0] FUSE = 4'(FUSE_SECONDS);
    localparam logic [3:0] COOL = 4'(COOLDOWN_SECONDS);

    typedef enum logic [1:0] {IDLE, ARMED, EXPLODE, COOLDOWN} state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    sec_cnt;
    logic          place_q;
    logic          place_edge;

    assign place_edge = bus.place & ~place_q;
    assign bus.ready  = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            tick_cnt          <= '0;
            sec_cnt           <= '0;
            place_q           <= 1'b1;
            bus.bombPosX      <= '0;
            bus.bombPosY      <= '0;
            bus.bombActive    <= 1'b0;
            bus.bombExploded  <= 1'b0;
            bus.fuseRemaining <= '0;
        end else begin
            place_q <= bus.place;
            case (state)
                IDLE: if (place_edge && !bus.stunned) begin
                    bus.bombPosX      <= bus.playerPosX;
                    bus.bombPosY      <= bus.playerPosY;
                    bus.bombActive    <= 1'b1;
                    bus.fuseRemaining <= FUSE;
                    sec_cnt           <= FUSE;
                    tick_cnt          <= TICK_MAX;
                    state             <= ARMED;
                end
                ARMED: if (tick_cnt != '0) begin
                    tick_cnt <= tick_cnt - 1'b1;
                end else if (sec_cnt == 4'd1) begin
                    bus.bombExploded  <= 1'b1;
                    bus.fuseRemaining <= '0;
                    state             <= EXPLODE;
                end else begin
                    sec_cnt           <= sec_cnt - 4'd1;
                    bus.fuseRemaining <= sec_cnt - 4'd1;
                    tick_cnt          <= TICK_MAX;
                end
                EXPLODE: begin
                    bus.bombExploded <= 1'b0;
                    bus.bombActive   <= 1'b0;
                    sec_cnt          <= COOL;
                    tick_cnt         <= TICK_MAX;
                    state            <= (COOL == 4'd0) ? IDLE : COOLDOWN;
                end
                COOLDOWN: if (tick_cnt != '0) begin
                    tick_cnt <= tick_cnt - 1'b1;
                end else if (sec_cnt == 4'd1) begin
                    state <= IDLE;
                end else begin
                    sec_cnt  <= sec_cnt - 4'd1;
                    tick_cnt <= TICK_MAX;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
